opb_bus_monitor: RTL and testbench
==================================

# opb_bus_monitor

Response combiner and watchdog sitting between the OPB slave wrappers (software-register slaves such as the board-ID register) and the OPB master port. It OR-reduces the slave response buses of C_NUM_SLAVES slaves into a single response, generates a bus error (errAck) when a selected transfer is not acknowledged within C_TIMEOUT cycles, and keeps error and transfer statistics with a sticky interrupt for software.

## Interface
Parameters:
- C_NUM_SLAVES, 8: number of slave response lanes (1..32)
- C_TIMEOUT, 16: counted cycles without acknowledge before a timeout error (2..255)
- C_OPB_DWIDTH, 32: data/address width (fixed at 32)

Ports:
- OPB_Clk  in  1  bus clock; all logic on rising edge
- OPB_Rst_n  in  1  synchronous, active-low reset
- OPB_select  in  1  master select
- OPB_ABus  in  [0:31]  transfer address
- OPB_RNW  in  1  read-not-write
- Sl_DBus_vec  in  [0:32*C_NUM_SLAVES-1]  slave read data; lane k occupies bits 32k..32k+31
- Sl_xferAck_vec, Sl_errAck_vec, Sl_retry_vec, Sl_toutSup_vec  in  [0:C_NUM_SLAVES-1]  per-slave responses
- Mon_DBus  out  [0:31]  OR of all Sl_DBus lanes (combinational)
- Mon_xferAck  out  1  OR of Sl_xferAck_vec (combinational)
- Mon_errAck  out  1  OR of Sl_errAck_vec, OR'd with tout_err (registered)
- Mon_retry, Mon_toutSup  out  1  OR of respective vectors (combinational)
- irq_clr  in  1  single-cycle pulse; clears err_irq
- err_irq  out  1  sticky error flag
- timeout_count  out  [15:0]  saturating count of timeouts
- multi_ack_count  out  [15:0]  saturating count of multi-slave acknowledges
- xfer_count  out  [31:0]  wrapping count of cycles with Mon_xferAck=1
- last_err_addr  out  [0:31]  OPB_ABus captured at the last timeout
- last_err_rnw  out  1  OPB_RNW captured at the last timeout

## Operation
- FSM states: IDLE, WAIT, TOUT, HOLD.
- IDLE: OPB_select=1 -> WAIT. wait_cnt loads 1 if no ack and no toutSup this cycle; otherwise 0.
- "ack" = any bit of Sl_xferAck_vec | Sl_errAck_vec | Sl_retry_vec.
- WAIT, evaluated in priority order:
  - ack -> IDLE; wait_cnt=0.
  - OPB_select=0 (master abort) -> IDLE; no error.
  - any Sl_toutSup_vec bit -> stay; wait_cnt held.
  - wait_cnt==C_TIMEOUT-1 -> TOUT.
  - otherwise wait_cnt+1.
- wait_cnt width: 8 bits.
- TOUT (exactly one cycle):
  - tout_err=1.
  - last_err_addr/last_err_rnw capture OPB_ABus/OPB_RNW.
  - timeout_count+1, saturating at 0xFFFF.
  - err_irq set.
  - Next state HOLD.
- HOLD: wait for OPB_select=0 -> IDLE. No second error is generated for the same select period, and any late ack is ignored by the FSM.
- Multi-ack: in any state, a cycle with more than one bit of Sl_xferAck_vec set increments multi_ack_count (saturating) and sets err_irq. Combined outputs still OR.
- xfer_count increments every cycle Mon_xferAck=1, wrapping from 0xFFFFFFFF to 0.
- err_irq: set has priority over irq_clr in the same cycle.
- C_NUM_SLAVES=1: multi-ack detection is never true.

## Timing
- Reset (OPB_Rst_n=0 at a clock edge): state IDLE; wait_cnt, tout_err, err_irq, all counters, last_err_addr and last_err_rnw are 0. Combinational outputs follow their inputs, so they are 0 if the slaves are idle.
- Reset asserted mid-WAIT/TOUT/HOLD: state goes to IDLE on that edge. No error is flagged, and the counters clear.
- Mon_DBus, Mon_xferAck, Mon_retry, Mon_toutSup: zero latency.
- Timeout timing: first select-high cycle is cycle 0, with no acks or toutSup. Mon_errAck is high for exactly cycle C_TIMEOUT; the statistics update at the end of that cycle.
- Each toutSup cycle delays the timeout by one cycle.
- An ack in cycle C_TIMEOUT-1 wins: no error.
- A slave errAck in the same cycle as tout_err gives one errAck cycle; Mon_errAck is a plain OR.
- err_irq rises the cycle after the causing event edge, i.e. it is registered.

## Test plan
- Slave 3 acks a read in cycle 2 of select, Sl_DBus lane 3 = 0xDEADBEEF -> Mon_DBus=0xDEADBEEF and Mon_xferAck high in the same cycle; xfer_count=1; no error.
- Select held with no ack, C_TIMEOUT=16, OPB_ABus=0x01004700, RNW=1 -> Mon_errAck high only in cycle 16; timeout_count=1; last_err_addr=0x01004700; last_err_rnw=1; err_irq=1; no second error while select stays high 40 cycles.
- Select held with toutSup asserted on cycles 3..12 and no ack -> errAck in cycle 26; an ack arriving in cycle 15 instead -> no error.
- Slaves 0 and 5 xferAck simultaneously -> multi_ack_count=1, err_irq=1; irq_clr pulse on the same cycle as a new timeout -> err_irq stays 1.
- Pre-load timeout_count to 0xFFFF via repeated timeouts (or force) -> the next timeout leaves it at 0xFFFF. Then assert OPB_Rst_n=0 mid-WAIT -> all counters 0, state IDLE, and no errAck in the following cycles.

Source files
------------

// File: rtl/opb_bus_monitor.sv
// OPB response combiner and watchdog.
// Combines the slave response lanes into one master-facing response. Raises a
// bus error when a selected transfer goes unacknowledged for too long, and
// keeps statistics plus a sticky interrupt flag for software.
module opb_bus_monitor #(
  parameter int unsigned C_NUM_SLAVES = 8,
  parameter int unsigned C_TIMEOUT    = 16,
  parameter int unsigned C_OPB_DWIDTH = 32
) (
  input  logic                                 OPB_Clk,
  input  logic                                 OPB_Rst_n,
  input  logic                                 OPB_select,
  input  logic [0:C_OPB_DWIDTH-1]              OPB_ABus,
  input  logic                                 OPB_RNW,
  input  logic [0:C_OPB_DWIDTH*C_NUM_SLAVES-1] Sl_DBus_vec,
  input  logic [0:C_NUM_SLAVES-1]              Sl_xferAck_vec,
  input  logic [0:C_NUM_SLAVES-1]              Sl_errAck_vec,
  input  logic [0:C_NUM_SLAVES-1]              Sl_retry_vec,
  input  logic [0:C_NUM_SLAVES-1]              Sl_toutSup_vec,
  output logic [0:C_OPB_DWIDTH-1]              Mon_DBus,
  output logic                                 Mon_xferAck,
  output logic                                 Mon_errAck,
  output logic                                 Mon_retry,
  output logic                                 Mon_toutSup,
  input  logic                                 irq_clr,
  output logic                                 err_irq,
  output logic [15:0]                          timeout_count,
  output logic [15:0]                          multi_ack_count,
  output logic [31:0]                          xfer_count,
  output logic [0:C_OPB_DWIDTH-1]              last_err_addr,
  output logic                                 last_err_rnw
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_TOUT,
    S_HOLD
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(C_TIMEOUT - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_wait_cnt;
  logic [7:0]                w_wait_cnt_nxt;
  logic                      r_tout_err;
  logic                      r_err_irq;
  logic [15:0]               r_timeout_count;
  logic [15:0]               r_multi_ack_count;
  logic [31:0]               r_xfer_count;
  logic [0:C_OPB_DWIDTH-1]   r_last_err_addr;
  logic                      r_last_err_rnw;

  logic [0:C_OPB_DWIDTH-1]   w_dbus_or;
  logic                      w_ack;
  logic                      w_sup;
  logic                      w_xack_seen;
  logic                      w_multi_ack;

  // OR-reduce all slave read-data lanes onto the master bus
  always_comb begin
    w_dbus_or = '0;
    for (int unsigned k = 0; k < C_NUM_SLAVES; k++) begin
      w_dbus_or = w_dbus_or | Sl_DBus_vec[k*C_OPB_DWIDTH +: C_OPB_DWIDTH];
    end
  end

  // Detect more than one slave asserting xferAck in the same cycle
  always_comb begin
    w_xack_seen = 1'b0;
    w_multi_ack = 1'b0;
    for (int unsigned k = 0; k < C_NUM_SLAVES; k++) begin
      if (Sl_xferAck_vec[k]) begin
        if (w_xack_seen) begin
          w_multi_ack = 1'b1;
        end
        w_xack_seen = 1'b1;
      end
    end
  end

  assign w_ack       = |(Sl_xferAck_vec | Sl_errAck_vec | Sl_retry_vec);
  assign w_sup       = |Sl_toutSup_vec;

  assign Mon_DBus    = w_dbus_or;
  assign Mon_xferAck = |Sl_xferAck_vec;
  assign Mon_retry   = |Sl_retry_vec;
  assign Mon_toutSup = |Sl_toutSup_vec;
  assign Mon_errAck  = (|Sl_errAck_vec) | r_tout_err;

  assign err_irq         = r_err_irq;
  assign timeout_count   = r_timeout_count;
  assign multi_ack_count = r_multi_ack_count;
  assign xfer_count      = r_xfer_count;
  assign last_err_addr   = r_last_err_addr;
  assign last_err_rnw    = r_last_err_rnw;

  // Watchdog next-state and wait counter
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (OPB_select) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = (w_ack || w_sup) ? 8'd0 : 8'd1;
        end
      end
      S_WAIT: begin
        if (w_ack || !OPB_select) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (w_sup) begin
          w_wait_cnt_nxt = r_wait_cnt;
        end else if (r_wait_cnt == LP_CNT_LAST) begin
          w_state_nxt    = S_TOUT;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
      end
      S_TOUT: begin
        w_state_nxt    = S_HOLD;
        w_wait_cnt_nxt = '0;
      end
      S_HOLD: begin
        if (!OPB_select) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Watchdog state register; tout_err is high exactly while in TOUT
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_tout_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_tout_err <= (w_state_nxt == S_TOUT);
    end
  end

  // Statistics, error capture and sticky interrupt (set beats clear)
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_timeout_count   <= '0;
      r_multi_ack_count <= '0;
      r_xfer_count      <= '0;
      r_last_err_addr   <= '0;
      r_last_err_rnw    <= 1'b0;
      r_err_irq         <= 1'b0;
    end else begin
      if (r_tout_err) begin
        r_last_err_addr <= OPB_ABus;
        r_last_err_rnw  <= OPB_RNW;
        if (r_timeout_count != '1) begin
          r_timeout_count <= r_timeout_count + 16'd1;
        end
      end
      if (w_multi_ack && (r_multi_ack_count != '1)) begin
        r_multi_ack_count <= r_multi_ack_count + 16'd1;
      end
      if (Mon_xferAck) begin
        r_xfer_count <= r_xfer_count + 32'd1;
      end
      if (r_tout_err || w_multi_ack) begin
        r_err_irq <= 1'b1;
      end else if (irq_clr) begin
        r_err_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opb_bus_monitor.sv
// Self-checking bench for opb_bus_monitor: directed scenarios plus random
// traffic, checked every cycle against a select-period behavioural model.
module tb_opb_bus_monitor;

  localparam int N = 8;
  localparam int T = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sel;
  logic [0:31]     abus;
  logic            rnw;
  logic [0:32*N-1] dbus_vec;
  logic [0:N-1]    xack, eack, retry, sup;
  logic            irq_clr;

  logic [0:31]     mon_dbus;
  logic            mon_xack, mon_eack, mon_retry, mon_sup;
  logic            err_irq;
  logic [15:0]     tcnt, macnt;
  logic [31:0]     xcnt;
  logic [0:31]     lea;
  logic            lern;

  int n_cmp = 0;
  int n_err = 0;

  opb_bus_monitor #(
    .C_NUM_SLAVES (N),
    .C_TIMEOUT    (T),
    .C_OPB_DWIDTH (32)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_select      (sel),
    .OPB_ABus        (abus),
    .OPB_RNW         (rnw),
    .Sl_DBus_vec     (dbus_vec),
    .Sl_xferAck_vec  (xack),
    .Sl_errAck_vec   (eack),
    .Sl_retry_vec    (retry),
    .Sl_toutSup_vec  (sup),
    .Mon_DBus        (mon_dbus),
    .Mon_xferAck     (mon_xack),
    .Mon_errAck      (mon_eack),
    .Mon_retry       (mon_retry),
    .Mon_toutSup     (mon_sup),
    .irq_clr         (irq_clr),
    .err_irq         (err_irq),
    .timeout_count   (tcnt),
    .multi_ack_count (macnt),
    .xfer_count      (xcnt),
    .last_err_addr   (lea),
    .last_err_rnw    (lern)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A select period is either counting unacknowledged cycles, already timed
  // out (waiting for select to drop), or not in progress.
  bit          m_valid = 1'b0;
  bit          m_active, m_fired, m_tout;
  int unsigned m_cnt;
  logic [15:0] m_tcnt, m_macnt;
  logic [31:0] m_xcnt, m_addr;
  logic        m_rnw, m_irq;
  int          pre_req = 0;
  int          pre_seen = 0;

  always @(negedge clk) begin
    logic [31:0] e_db;
    bit a, s, multi, tnext;
    if (pre_req != pre_seen) begin
      m_tcnt   = 16'hFFFF;
      pre_seen = pre_req;
    end
    if (m_valid) begin
      e_db = '0;
      for (int k = 0; k < N; k++) e_db = e_db | dbus_vec[32*k +: 32];
      chk("Mon_DBus",     64'(mon_dbus),  64'(e_db));
      chk("Mon_xferAck",  64'(mon_xack),  64'(|xack));
      chk("Mon_retry",    64'(mon_retry), 64'(|retry));
      chk("Mon_toutSup",  64'(mon_sup),   64'(|sup));
      chk("Mon_errAck",   64'(mon_eack),  64'((|eack) | m_tout));
      chk("err_irq",      64'(err_irq),   64'(m_irq));
      chk("timeout_cnt",  64'(tcnt),      64'(m_tcnt));
      chk("multi_ack_cnt",64'(macnt),     64'(m_macnt));
      chk("xfer_count",   64'(xcnt),      64'(m_xcnt));
      chk("last_err_addr",64'(lea),       64'(m_addr));
      chk("last_err_rnw", 64'(lern),      64'(m_rnw));
    end
    if (!rst_n) begin
      m_valid = 1'b1;
      m_active = 0; m_fired = 0; m_tout = 0; m_cnt = 0;
      m_tcnt = '0; m_macnt = '0; m_xcnt = '0; m_addr = '0; m_rnw = 1'b0; m_irq = 1'b0;
    end else if (m_valid) begin
      a     = |(xack | eack | retry);
      s     = |sup;
      multi = $countones(xack) > 1;
      if (m_tout) begin
        m_addr = abus;
        m_rnw  = rnw;
        if (m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
      end
      if (multi && m_macnt != 16'hFFFF) m_macnt = m_macnt + 16'd1;
      if (|xack) m_xcnt = m_xcnt + 32'd1;
      if (m_tout || multi) m_irq = 1'b1;
      else if (irq_clr)    m_irq = 1'b0;
      tnext = 1'b0;
      if (m_tout) begin
        // timeout cycle: period stays "fired" regardless of select
      end else if (m_fired) begin
        if (!sel) m_fired = 1'b0;
      end else if (!m_active) begin
        if (sel) begin
          m_active = 1'b1;
          m_cnt    = (a || s) ? 0 : 1;
        end
      end else begin
        if (a || !sel) m_active = 1'b0;
        else if (s) m_cnt = m_cnt;
        else if (m_cnt == T - 1) begin
          m_active = 1'b0;
          m_fired  = 1'b1;
          tnext    = 1'b1;
        end else m_cnt = m_cnt + 1;
      end
      m_tout = tnext;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sel = 0; xack = '0; eack = '0; retry = '0; sup = '0; irq_clr = 0;
    dbus_vec = '0;
  endtask

  initial begin
    int ea_cnt, ea_at;
    bit rsel;
    int r;

    rst_n = 0; abus = '0; rnw = 0;
    idle_inputs();
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst timeout_count", 64'(tcnt), 64'd0);
    chk("rst xfer_count",    64'(xcnt), 64'd0);
    chk("rst err_irq",       64'(err_irq), 64'd0);
    chk("rst Mon_errAck",    64'(mon_eack), 64'd0);

    // Slave 3 acknowledges a read in cycle 2 of select
    sel = 1; rnw = 1; abus = 32'h0000_1000;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        xack[3] = 1'b1;
        dbus_vec[32*3 +: 32] = 32'hDEADBEEF;
      end
      @(negedge clk);
      if (c == 2) begin
        chk("read Mon_DBus",    64'(mon_dbus), 64'h0000_0000_DEAD_BEEF);
        chk("read Mon_xferAck", 64'(mon_xack), 64'd1);
      end
      tick();
    end
    idle_inputs();
    tick();
    chk("read xfer_count", 64'(xcnt), 64'd1);
    chk("read no error",   64'(tcnt), 64'd0);

    // Plain timeout, select held 46 cycles
    sel = 1; abus = 32'h0100_4700; rnw = 1;
    ea_cnt = 0; ea_at = -1;
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (mon_eack) begin ea_cnt++; ea_at = c; end
      tick();
    end
    idle_inputs();
    abus = '0; rnw = 0;
    tick();
    chk("tout errAck cycles", 64'(ea_cnt), 64'd1);
    chk("tout errAck cycle",  64'(ea_at), 64'(T));
    chk("tout count",         64'(tcnt), 64'd1);
    chk("tout addr",          64'(lea), 64'h0100_4700);
    chk("tout rnw",           64'(lern), 64'd1);
    chk("tout irq",           64'(err_irq), 64'd1);

    // toutSup on cycles 3..12 delays the timeout by ten cycles
    sel = 1;
    ea_cnt = 0; ea_at = -1;
    for (int c = 0; c < 36; c++) begin
      sup[2] = (c >= 3 && c <= 12);
      @(negedge clk);
      if (mon_eack) begin ea_cnt++; ea_at = c; end
      tick();
    end
    idle_inputs();
    tick();
    chk("sup errAck cycles", 64'(ea_cnt), 64'd1);
    chk("sup errAck cycle",  64'(ea_at), 64'(T + 10));

    // Same suppression, ack in cycle 15 wins
    sel = 1;
    ea_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      sup[2]  = (c >= 3 && c <= 12);
      xack[1] = (c == 15);
      @(negedge clk);
      if (mon_eack) ea_cnt++;
      tick();
    end
    idle_inputs();
    repeat (20) begin
      @(negedge clk);
      if (mon_eack) ea_cnt++;
      tick();
    end
    chk("late ack no error", 64'(ea_cnt), 64'd0);
    chk("late ack tcount",   64'(tcnt), 64'd2);

    // Clear irq, then a double acknowledge from slaves 0 and 5
    irq_clr = 1; tick(); irq_clr = 0;
    chk("irq cleared", 64'(err_irq), 64'd0);
    sel = 1; xack[0] = 1; xack[5] = 1;
    tick();
    idle_inputs();
    chk("multi count", 64'(macnt), 64'd1);
    chk("multi irq",   64'(err_irq), 64'd1);
    irq_clr = 1; tick(); irq_clr = 0;
    tick();

    // Timeout with irq_clr pulsed in the errAck cycle: set wins
    sel = 1;
    for (int c = 0; c < T + 2; c++) begin
      irq_clr = (c == T);
      tick();
    end
    idle_inputs();
    tick();
    chk("set beats clear", 64'(err_irq), 64'd1);

    // Saturation: pre-load the timeout counter, then one more timeout
    @(posedge clk);
    force dut.r_timeout_count = 16'hFFFF;
    pre_req++;
    #1;
    release dut.r_timeout_count;
    sel = 1;
    repeat (T + 2) tick();
    idle_inputs();
    tick();
    chk("tout saturate", 64'(tcnt), 64'hFFFF);

    // Reset asserted mid-WAIT
    sel = 1;
    repeat (5) tick();
    rst_n = 0;
    tick();
    rst_n = 1; sel = 0;
    ea_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mon_eack) ea_cnt++;
      tick();
    end
    chk("rst mid errAck", 64'(ea_cnt), 64'd0);
    chk("rst mid tcount", 64'(tcnt), 64'd0);
    chk("rst mid macnt",  64'(macnt), 64'd0);
    chk("rst mid xcnt",   64'(xcnt), 64'd0);
    chk("rst mid irq",    64'(err_irq), 64'd0);

    // Random traffic against the model
    rsel = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rsel) rsel = ($urandom_range(0, 39) != 0);
      else      rsel = ($urandom_range(0, 3) == 0);
      sel  = rsel;
      abus = $urandom;
      rnw  = $urandom_range(0, 1) == 1;
      for (int k = 0; k < N; k++) dbus_vec[32*k +: 32] = $urandom;
      xack = '0; eack = '0; retry = '0; sup = '0;
      r = $urandom_range(0, 99);
      if (r < 3) xack[$urandom_range(0, N-1)] = 1'b1;
      else if (r == 3) begin
        xack[$urandom_range(0, N-1)] = 1'b1;
        xack[$urandom_range(0, N-1)] = 1'b1;
      end else if (r == 4) eack[$urandom_range(0, N-1)] = 1'b1;
      else if (r == 5) retry[$urandom_range(0, N-1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) sup[$urandom_range(0, N-1)] = 1'b1;
      irq_clr = ($urandom_range(0, 19) == 0);
      rst_n   = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle_inputs();
    rst_n = 1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
